// File: rtl/adc_spi_responder_pkg.sv
// rtl/adc_spi_responder_pkg.sv - shared constants, FSM state type and config decode for the ADC responder
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CFG_W  = 6;
    localparam int ADC_NCH    = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Config word layout is {S/D, O/S, S1, S0, UNI, SLP}; channel select is {S1, S0, O/S}.
    function automatic logic [2:0] cfg_to_ch(input logic [ADC_CFG_W-1:0] cfg);
        return {cfg[3], cfg[2], cfg[4]};
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - SPI wires between the ADC controller and the responder
interface adc_spi_responder_if;

    logic ADC_SCLK;
    logic ADC_CS_N;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_SCLK,
        output ADC_CS_N,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_SCLK,
        input  ADC_CS_N,
        input  ADC_DIN,
        output ADC_DOUT
    );

endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// rtl/adc_spi_responder_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synchronized level
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the async input through the chain and remember the last synchronized level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI ADC slave emulator: decodes the config word and returns channel samples
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CFG_W       = ADC_CFG_W,
    parameter int NCH         = ADC_NCH,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    adc_spi_responder_if.slave spi,
    input  logic [DATA_W-1:0] CH0,
    input  logic [DATA_W-1:0] CH1,
    input  logic [DATA_W-1:0] CH2,
    input  logic [DATA_W-1:0] CH3,
    input  logic [DATA_W-1:0] CH4,
    input  logic [DATA_W-1:0] CH5,
    input  logic [DATA_W-1:0] CH6,
    input  logic [DATA_W-1:0] CH7,
    output logic [CFG_W-1:0]  CFG,
    output logic              CFG_VALID,
    output logic              FRAME_ERR
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic din_s, din_rise_unused, din_fall_unused;

    state_t            state;
    logic [3:0]        rise_cnt;
    logic [CFG_W-1:0]  cfg_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [2:0]        ch_sel;
    logic [DATA_W-1:0] ch_arr [NCH];

    assign ch_arr[0] = CH0;
    assign ch_arr[1] = CH1;
    assign ch_arr[2] = CH2;
    assign ch_arr[3] = CH3;
    assign ch_arr[4] = CH4;
    assign ch_arr[5] = CH5;
    assign ch_arr[6] = CH6;
    assign ch_arr[7] = CH7;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(CLOCK), .rst(RESET), .d(spi.ADC_SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CS_N resets low so a select held low across reset release never looks like a frame start.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(CLOCK), .rst(RESET), .d(spi.ADC_CS_N), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
        .clk(CLOCK), .rst(RESET), .d(spi.ADC_DIN), .q(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    // DOUT is the MSB of tx_sr, which is kept at zero outside a frame.
    assign spi.ADC_DOUT = tx_sr[DATA_W-1];

    // Frame FSM: snapshot on CS_N fall, collect config on SCLK rise, shift data on SCLK fall, commit or flag on CS_N rise.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            rise_cnt  <= '0;
            cfg_sr    <= '0;
            tx_sr     <= '0;
            ch_sel    <= '0;
            CFG       <= '0;
            CFG_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            CFG_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_sr    <= ch_arr[ch_sel];
                        rise_cnt <= '0;
                        cfg_sr   <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // CS_N rise takes priority; an SCLK edge in the same cycle is dropped.
                    if (cs_rise) begin
                        tx_sr <= '0;
                        state <= IDLE;
                        if (rise_cnt == 4'(DATA_W)) begin
                            CFG       <= cfg_sr;
                            ch_sel    <= cfg_to_ch(cfg_sr);
                            CFG_VALID <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            if (rise_cnt < 4'(CFG_W)) begin
                                cfg_sr <= {cfg_sr[CFG_W-2:0], din_s};
                            end
                            if (rise_cnt != 4'd15) begin
                                rise_cnt <= rise_cnt + 4'd1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
